// File: rtl/check_node_unit.sv
// Serial min-sum check node: collects DEG VNU messages, then emits DEG extrinsic messages.
// Optional CNU_OFFSET_EN selects offset min-sum (emitted magnitude reduced by one, floored at 0).
module check_node_unit #(
  parameter  int unsigned DEG = 6,
  localparam int unsigned CW  = $clog2(DEG)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_msg,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_msg,
  output logic       out_last,
  output logic       syndrome,
  output logic       syndrome_valid
);

  localparam int unsigned MW = 4;

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt, cnt_nxt, idx, idx_n;
  logic [MW-1:0]     min1, min2, min1_n, min2_n, mag;
  logic              sign_acc, sign_acc_n, hd_acc, hd_acc_n;
  logic [DEG-1:0]    sign_vec, sign_vec_n;
  logic              accept, last_edge, out_hs;

  // Extrinsic message for edge i from the collected minima and signs
  function automatic logic [4:0] cnu_msg(input logic [CW-1:0] i, input logic [MW-1:0] m1,
                                         input logic [MW-1:0] m2, input logic [CW-1:0] ix,
                                         input logic sa, input logic [DEG-1:0] sv);
    logic [MW-1:0] m;
    m = (i == ix) ? m2 : m1;
`ifdef CNU_OFFSET_EN
    if (m != MW'(0)) m = m - MW'(1);
`endif
    return {sa ^ sv[i], m};
  endfunction

  assign in_ready  = (state_q == COLLECT);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_edge = (cnt == CW'(DEG - 1));
  assign cnt_nxt   = cnt + CW'(1);
  assign mag       = in_msg[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && last_edge)  state_d = EMIT;
      EMIT:    if (out_hs && out_last)   state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Running min1/min2/idx update including the edge currently on in_msg
  always_comb begin
    min1_n     = min1;
    min2_n     = min2;
    idx_n      = idx;
    sign_acc_n = sign_acc ^ in_msg[4];
    hd_acc_n   = hd_acc ^ in_msg[5];
    sign_vec_n = sign_vec | (DEG'(in_msg[4]) << cnt);
    if (mag < min1) begin
      min2_n = min1;
      min1_n = mag;
      idx_n  = cnt;
    end else if (mag < min2) begin
      min2_n = mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      min1           <= MW'(15);
      min2           <= MW'(15);
      idx            <= '0;
      sign_acc       <= 1'b0;
      hd_acc         <= 1'b0;
      sign_vec       <= '0;
      out_msg        <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      syndrome       <= 1'b0;
      syndrome_valid <= 1'b0;
    end else begin
      syndrome_valid <= 1'b0;
      if (accept) begin
        min1     <= min1_n;
        min2     <= min2_n;
        idx      <= idx_n;
        sign_acc <= sign_acc_n;
        hd_acc   <= hd_acc_n;
        sign_vec <= sign_vec_n;
        if (last_edge) begin
          cnt            <= '0;
          syndrome       <= hd_acc_n;
          syndrome_valid <= 1'b1;
          out_msg        <= cnu_msg(CW'(0), min1_n, min2_n, idx_n, sign_acc_n, sign_vec_n);
          out_valid      <= 1'b1;
          out_last       <= 1'b0;
        end else begin
          cnt <= cnt_nxt;
        end
      end
      if (out_hs) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          cnt       <= '0;
          min1      <= MW'(15);
          min2      <= MW'(15);
          idx       <= '0;
          sign_acc  <= 1'b0;
          hd_acc    <= 1'b0;
          sign_vec  <= '0;
        end else begin
          cnt      <= cnt_nxt;
          out_msg  <= cnu_msg(cnt_nxt, min1, min2, idx, sign_acc, sign_vec);
          out_last <= (cnt_nxt == CW'(DEG - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_check_node_unit.sv
// Bench for check_node_unit: directed table vectors, a mid-collection reset, and randomized
// handshake traffic checked against a behavioural min-sum model (honours CNU_OFFSET_EN).
module tb_check_node_unit;

  localparam int DEG = 6;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
  logic       syndrome, syndrome_valid;
  logic [5:0] in_msg;
  logic [4:0] out_msg;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] mag  [DEG];
    logic       sgn  [DEG];
    logic       hd   [DEG];
    logic [3:0] emag [DEG];
    logic       esgn [DEG];
    logic       esyn;
  } vec_t;

  vec_t       tbl [4];
  logic [3:0] cur_mag [DEG];
  logic       cur_sgn [DEG];
  logic       cur_hd  [DEG];
  logic [3:0] exp_mag [DEG];
  logic       exp_sgn [DEG];
  logic       exp_syn;

  check_node_unit #(.DEG(DEG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg), .out_last(out_last),
    .syndrome(syndrome), .syndrome_valid(syndrome_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Extrinsic value = min over the other edges, sign = XOR of the other signs
  task automatic model();
    for (int i = 0; i < DEG; i++) begin
      int best;
      logic s;
      best = 15;
      s = 1'b0;
      for (int j = 0; j < DEG; j++) begin
        if (j != i) begin
          if (int'(cur_mag[j]) < best) best = int'(cur_mag[j]);
          s ^= cur_sgn[j];
        end
      end
`ifdef CNU_OFFSET_EN
      if (best > 0) best--;
`endif
      exp_mag[i] = 4'(best);
      exp_sgn[i] = s;
    end
    exp_syn = 1'b0;
    for (int j = 0; j < DEG; j++) exp_syn ^= cur_hd[j];
  endtask

  task automatic run_check(input int stall_pct, input int gap_pct, input bit junk);
    int  i, budget;
    bit  rdy;
    for (int e = 0; e < DEG; e++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      chk("in_ready_collect", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_msg   = {cur_hd[e], cur_sgn[e], cur_mag[e]};
      @(negedge clk);
      if (e < DEG - 1) chk("out_valid_collect", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    chk("syndrome_valid_pulse", 32'(syndrome_valid), 32'd1);
    chk("syndrome", 32'(syndrome), 32'(exp_syn));
    i = 0;
    budget = 0;
    while (i < DEG) begin
      if (budget > 500) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d outputs expected %0d", i, DEG);
        break;
      end
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("in_ready_emit", 32'(in_ready), 32'd0);
      chk("out_msg", 32'(out_msg), 32'({exp_sgn[i], exp_mag[i]}));
      chk("out_last", 32'(out_last), 32'(i == DEG - 1));
      if (budget > 0) chk("syndrome_valid_low", 32'(syndrome_valid), 32'd0);
      out_ready = (int'($urandom_range(99)) >= stall_pct);
      if (junk) begin
        in_valid = 1'($urandom);
        in_msg   = 6'($urandom);
      end
      rdy = out_ready;
      @(negedge clk);
      if (rdy) i++;
      budget++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("out_valid_done", 32'(out_valid), 32'd0);
    chk("in_ready_done", 32'(in_ready), 32'd1);
    chk("syndrome_hold", 32'(syndrome), 32'(exp_syn));
  endtask

  task automatic load_tbl(input int t);
    cur_mag = tbl[t].mag;
    cur_sgn = tbl[t].sgn;
    cur_hd  = tbl[t].hd;
    exp_mag = tbl[t].emag;
    exp_sgn = tbl[t].esgn;
    exp_syn = tbl[t].esyn;
  endtask

  initial begin
    tbl[0].mag  = '{4'd9, 4'd3, 4'd7, 4'd5, 4'd12, 4'd4};
    tbl[0].sgn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[0].hd   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[0].esgn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[0].esyn = 1'b0;
    tbl[1].mag  = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6};
    tbl[1].sgn  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1].hd   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1].esgn = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1].esyn = 1'b0;
    tbl[2].mag  = '{4'd2, 4'd2, 4'd8, 4'd8, 4'd8, 4'd8};
    tbl[2].sgn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2].hd   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2].esgn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2].esyn = 1'b0;
    tbl[3].mag  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    tbl[3].sgn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3].hd   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3].esgn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3].esyn = 1'b1;
`ifdef CNU_OFFSET_EN
    tbl[0].emag = '{4'd2, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2};
    tbl[1].emag = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    tbl[2].emag = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    tbl[3].emag = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
`else
    tbl[0].emag = '{4'd3, 4'd4, 4'd3, 4'd3, 4'd3, 4'd3};
    tbl[1].emag = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6};
    tbl[2].emag = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    tbl[3].emag = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_msg    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_msg", 32'(out_msg), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_syndrome", 32'(syndrome), 32'd0);
    chk("rst_syndrome_valid", 32'(syndrome_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, back-to-back with out_ready held high
    for (int t = 0; t < 4; t++) begin
      load_tbl(t);
      run_check(0, 0, 1'b0);
    end

    // Reset after 3 inputs; syndrome is 1 from the previous check and must clear
    for (int e = 0; e < 3; e++) begin
      in_valid = 1'b1;
      in_msg   = 6'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_syndrome", 32'(syndrome), 32'd0);
    chk("midrst_syndrome_valid", 32'(syndrome_valid), 32'd0);
    @(negedge clk);
    chk("midrst_hold_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    load_tbl(0);
    run_check(0, 0, 1'b0);

    // Randomized traffic with input gaps, output stalls and ignored input during emission
    for (int c = 0; c < 100; c++) begin
      for (int e = 0; e < DEG; e++) begin
        cur_mag[e] = 4'($urandom);
        cur_sgn[e] = 1'($urandom);
        cur_hd[e]  = 1'($urandom);
      end
      if (c % 10 == 0) for (int e = 0; e < DEG; e++) cur_mag[e] = cur_mag[0];
      model();
      run_check(40, 30, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
